// File: rtl/mac_pipe_n_if.sv
// Operand/result handshake bundle for mac_pipe_n: valid/ready beats in,
// valid/ready group results out.
interface mac_pipe_n_if #(
  parameter int WIDTH = 32,
  parameter int ACC_W = 2*WIDTH+8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             first;
  logic             last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic [CNT_W-1:0] count_out;
  logic             ovf_out;

  modport master (
    output in_valid, a, b, first, last, out_ready,
    input  in_ready, out_valid, acc_out, count_out, ovf_out
  );

  modport slave (
    input  in_valid, a, b, first, last, out_ready,
    output in_ready, out_valid, acc_out, count_out, ovf_out
  );
endinterface

// File: rtl/mac_pipe_n.sv
// Pipelined unsigned multiply-accumulate: operand register, product register,
// then accumulate/emit. Define MAC_SAT_EN to saturate acc on overflow instead of wrapping.
module mac_pipe_n #(
  parameter int WIDTH = 32,
  parameter int ACC_W = 2*WIDTH+8,
  parameter int CNT_W = 16
) (
  input logic        clk,
  input logic        rst,
  mac_pipe_n_if.slave bus
);

  logic adv;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic             s1_first_q, s1_first_d;
  logic             s1_last_q, s1_last_d;

  logic             s2_valid_q, s2_valid_d;
  logic [ACC_W-1:0] s2_prod_q, s2_prod_d;
  logic             s2_first_q, s2_first_d;
  logic             s2_last_q, s2_last_d;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] acc_out_q, acc_out_d;
  logic [CNT_W-1:0] count_out_q, count_out_d;
  logic             ovf_out_q, ovf_out_d;

  logic [2*WIDTH-1:0] prod_full;
  logic [ACC_W-1:0]   acc_base;
  logic [ACC_W:0]     sum;
  logic               ovf_next;
  logic [ACC_W-1:0]   acc_next;
  logic [CNT_W-1:0]   cnt_next;

  // The whole pipe moves as one; a held result freezes every stage.
  assign adv          = !out_valid_q || bus.out_ready;
  assign bus.in_ready = adv;

  assign prod_full = (2*WIDTH)'(s1_a_q) * (2*WIDTH)'(s1_b_q);

  always_comb begin
    acc_base = s2_first_q ? '0 : acc_q;
    sum      = {1'b0, acc_base} + {1'b0, s2_prod_q};
    ovf_next = (s2_first_q ? 1'b0 : ovf_q) | sum[ACC_W];
`ifdef MAC_SAT_EN
    acc_next = ovf_next ? '1 : sum[ACC_W-1:0];
`else
    acc_next = sum[ACC_W-1:0];
`endif
    if (s2_first_q)
      cnt_next = CNT_W'(1);
    else if (&cnt_q)
      cnt_next = cnt_q;
    else
      cnt_next = cnt_q + CNT_W'(1);
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_first_d  = s1_first_q;
    s1_last_d   = s1_last_q;
    s2_valid_d  = s2_valid_q;
    s2_prod_d   = s2_prod_q;
    s2_first_d  = s2_first_q;
    s2_last_d   = s2_last_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    acc_out_d   = acc_out_q;
    count_out_d = count_out_q;
    ovf_out_d   = ovf_out_q;

    if (adv) begin
      s1_valid_d  = bus.in_valid;
      s1_a_d      = bus.a;
      s1_b_d      = bus.b;
      s1_first_d  = bus.first;
      s1_last_d   = bus.last;

      s2_valid_d  = s1_valid_q;
      s2_prod_d   = ACC_W'(prod_full);
      s2_first_d  = s1_first_q;
      s2_last_d   = s1_last_q;

      // Any pending result is being taken this edge unless a new one replaces it.
      out_valid_d = 1'b0;

      if (s2_valid_q) begin
        acc_d = acc_next;
        cnt_d = cnt_next;
        ovf_d = ovf_next;
        if (s2_last_q) begin
          out_valid_d = 1'b1;
          acc_out_d   = acc_next;
          count_out_d = cnt_next;
          ovf_out_d   = ovf_next;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_prod_q   <= '0;
      s2_first_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      acc_out_q   <= '0;
      count_out_q <= '0;
      ovf_out_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      s2_valid_q  <= s2_valid_d;
      s2_prod_q   <= s2_prod_d;
      s2_first_q  <= s2_first_d;
      s2_last_q   <= s2_last_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      acc_out_q   <= acc_out_d;
      count_out_q <= count_out_d;
      ovf_out_q   <= ovf_out_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.acc_out   = acc_out_q;
  assign bus.count_out = count_out_q;
  assign bus.ovf_out   = ovf_out_q;

endmodule

// File: tb/tb_mac_pipe_n.sv
// Self-checking bench for mac_pipe_n: directed cases plus randomized groups
// scored against an arithmetic model of group sums.
module tb_mac_pipe_n;
  localparam int WIDTH = 32;
  localparam int ACC_W = 2*WIDTH+8;
  localparam int CNT_W = 16;
  localparam int SW    = 4;
  localparam int SACC  = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mac_pipe_n_if #(.WIDTH(WIDTH), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();
  mac_pipe_n_if #(.WIDTH(SW), .ACC_W(SACC), .CNT_W(CNT_W)) sbus ();

  mac_pipe_n #(.WIDTH(WIDTH), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  mac_pipe_n #(.WIDTH(SW), .ACC_W(SACC), .CNT_W(CNT_W)) dutSmall (
    .clk(clk),
    .rst(rst),
    .bus(sbus.slave)
  );

  typedef struct {
    logic [127:0] acc;
    logic [127:0] cnt;
    logic         ovf;
  } result_t;

  int           checkCount = 0;
  int           errorCount = 0;
  result_t      expQ[$];
  logic [127:0] modelSum = '0;
  logic [127:0] modelCnt = '0;
  logic         randomReady = 1'b0;
  logic         readyValue = 1'b1;

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Reference: the group total is kept as an exact integer; the DUT's
  // visible accumulator is that total reduced to ACC_W bits (or clipped).
  task automatic modelAccept(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic first, input logic last);
    logic [127:0] limit;
    result_t r;
    limit = 128'd1 << ACC_W;
    if (first) begin
      modelSum = '0;
      modelCnt = '0;
    end
    modelSum = modelSum + 128'(a) * 128'(b);
    if (modelCnt < 128'd65535) modelCnt = modelCnt + 128'd1;
    if (last) begin
      r.ovf = (modelSum >= limit);
`ifdef MAC_SAT_EN
      r.acc = r.ovf ? limit - 128'd1 : modelSum;
`else
      r.acc = modelSum % limit;
`endif
      r.cnt = modelCnt;
      expQ.push_back(r);
    end
  endtask

  // Monitor: score each handed-off result, then record any beat accepted this cycle.
  always @(negedge clk) begin
    result_t r;
    if (rst) begin
      expQ.delete();
      modelSum = '0;
      modelCnt = '0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected result", 128'd1, 128'd0);
        end else begin
          r = expQ.pop_front();
          checkOutput("model acc_out", 128'(bus.acc_out), r.acc);
          checkOutput("model count_out", 128'(bus.count_out), r.cnt);
          checkOutput("model ovf_out", 128'(bus.ovf_out), 128'(r.ovf));
        end
      end
      if (bus.in_valid && bus.in_ready)
        modelAccept(bus.a, bus.b, bus.first, bus.last);
    end
  end

  // Downstream ready: either a fixed level or random back-pressure.
  always @(posedge clk) begin
    #2;
    bus.out_ready = randomReady ? ($urandom_range(0, 3) != 0) : readyValue;
  end

  // Present one beat and hold it until the DUT takes it.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic first, input logic last);
    logic accepted;
    accepted     = 1'b0;
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.first    = first;
    bus.last     = last;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    checkOutput("beat accepted", 128'(accepted), 128'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    bus.in_valid = 1'b0;
    bus.first    = 1'b0;
    bus.last     = 1'b0;
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic waitResult(input string tag, input logic [127:0] expAcc,
                            input logic [127:0] expCnt, input logic expOvf);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput({tag, " valid"}, 128'(seen), 128'd1);
    checkOutput({tag, " acc"}, 128'(bus.acc_out), expAcc);
    checkOutput({tag, " count"}, 128'(bus.count_out), expCnt);
    checkOutput({tag, " ovf"}, 128'(bus.ovf_out), 128'(expOvf));
  endtask

  initial begin
    logic seen;
    int   len;
    logic [WIDTH-1:0] ra, rb;

    rst = 1'b1;
    idleInputs();
    bus.a = '0;
    bus.b = '0;
    sbus.in_valid  = 1'b0;
    sbus.a         = '0;
    sbus.b         = '0;
    sbus.first     = 1'b0;
    sbus.last      = 1'b0;
    sbus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    checkOutput("reset out_valid", 128'(bus.out_valid), 128'd0);
    checkOutput("reset acc_out", 128'(bus.acc_out), 128'd0);
    checkOutput("reset count_out", 128'(bus.count_out), 128'd0);
    checkOutput("reset ovf_out", 128'(bus.ovf_out), 128'd0);
    checkOutput("reset in_ready", 128'(bus.in_ready), 128'd1);
    @(posedge clk);
    #1;

    // Single-term group; result appears after the third edge counting the accepting one.
    applyStimulus(12, 12, 1'b1, 1'b1);
    idleInputs();
    @(negedge clk);
    checkOutput("latency edge0", 128'(bus.out_valid), 128'd0);
    @(negedge clk);
    checkOutput("latency edge1", 128'(bus.out_valid), 128'd0);
    @(negedge clk);
    checkOutput("latency edge2", 128'(bus.out_valid), 128'd1);
    checkOutput("single acc", 128'(bus.acc_out), 128'd144);
    checkOutput("single count", 128'(bus.count_out), 128'd1);
    checkOutput("single ovf", 128'(bus.ovf_out), 128'd0);
    @(posedge clk);
    #1;

    applyStimulus(15, 13, 1'b1, 1'b0);
    applyStimulus(24, 2, 1'b0, 1'b0);
    applyStimulus(200, 21, 1'b0, 1'b0);
    applyStimulus(36, 48, 1'b0, 1'b1);
    idleInputs();
    waitResult("group4", 128'd6171, 128'd4, 1'b0);
    @(posedge clk);
    #1;

    // Back-pressure: hold the first result while a second group sits behind it.
    readyValue = 1'b0;
    @(posedge clk);
    #3;
    applyStimulus(6, 7, 1'b1, 1'b0);
    applyStimulus(8, 9, 1'b0, 1'b1);
    applyStimulus(5, 5, 1'b1, 1'b1);
    idleInputs();
    waitResult("stall first", 128'd114, 128'd2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checkOutput("stall out_valid", 128'(bus.out_valid), 128'd1);
      checkOutput("stall in_ready", 128'(bus.in_ready), 128'd0);
      checkOutput("stall acc hold", 128'(bus.acc_out), 128'd114);
    end
    readyValue = 1'b1;
    @(posedge clk);
    #3;
    @(negedge clk);
    checkOutput("release acc", 128'(bus.acc_out), 128'd114);
    @(negedge clk);
    checkOutput("reload valid", 128'(bus.out_valid), 128'd1);
    checkOutput("reload acc", 128'(bus.acc_out), 128'd25);
    checkOutput("reload count", 128'(bus.count_out), 128'd1);
    @(posedge clk);
    #1;

    // Reset mid-group discards the partial sum.
    applyStimulus(1, 1, 1'b1, 1'b0);
    applyStimulus(2, 2, 1'b0, 1'b0);
    idleInputs();
    pulseReset();
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
      if (i == 0) checkOutput("post-reset in_ready", 128'(bus.in_ready), 128'd1);
    end
    checkOutput("no result after reset", 128'(seen), 128'd0);
    @(posedge clk);
    #1;
    applyStimulus(3, 7, 1'b1, 1'b1);
    idleInputs();
    waitResult("after reset", 128'd21, 128'd1, 1'b0);
    @(posedge clk);
    #1;

    // Group without a leading first continues from the cleared accumulator.
    pulseReset();
    applyStimulus(2, 3, 1'b0, 1'b0);
    applyStimulus(1, 4, 1'b0, 1'b1);
    idleInputs();
    waitResult("no first", 128'd10, 128'd2, 1'b0);
    @(posedge clk);
    #1;

    // Randomized groups under random back-pressure.
    randomReady = 1'b1;
    for (int g = 0; g < 60; g++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        ra = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 1000));
        rb = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 1000));
        applyStimulus(ra, rb, (i == 0) && ($urandom_range(0, 7) != 0), i == len - 1);
        if ($urandom_range(0, 4) == 0) begin
          idleInputs();
          @(posedge clk);
          #1;
        end
      end
    end
    idleInputs();
    randomReady = 1'b0;
    readyValue  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (expQ.size() == 0) break;
    end
    checkOutput("drain queue", 128'(expQ.size()), 128'd0);

    // Narrow instance: 20 x (15*15) overruns an 8-bit accumulator.
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      sbus.in_valid = 1'b1;
      sbus.a        = 4'd15;
      sbus.b        = 4'd15;
      sbus.first    = (i == 0);
      sbus.last     = (i == 19);
      @(posedge clk);
      #1;
    end
    sbus.in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sbus.out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("narrow valid", 128'(seen), 128'd1);
`ifdef MAC_SAT_EN
    checkOutput("narrow acc", 128'(sbus.acc_out), 128'd255);
`else
    checkOutput("narrow acc", 128'(sbus.acc_out), 128'd148);
`endif
    checkOutput("narrow count", 128'(sbus.count_out), 128'd20);
    checkOutput("narrow ovf", 128'(sbus.ovf_out), 128'd1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end
endmodule
